osc_tick_gen: RTL and testbench

Multi-channel, parametrised tick and blink generator clocked from the fabric copy of the 25/50 MHz on-chip RC oscillator (`RCOSC_25_50MHZ_O2F` after its CLKINT global buffer). It replaces the per-design hand-written divide counters. It produces N independent programmable-rate single-cycle tick strobes and 50 % toggle outputs, used for LED blink, timeouts and sample strobes. Divisors are run-time writable through a simple register-write port. A common SYNC input phase-aligns all channels.

---
 rtl/osc_tick_pkg.sv | 26 ++
 rtl/osc_tick_chan.sv | 78 +++++++
 rtl/osc_tick_gen.sv | 50 +++++
 tb/tb_osc_tick_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/osc_tick_pkg.sv
// Shared constants and helpers for the oscillator-derived tick generator.
package osc_tick_pkg;

  // Reset divisors that give a 2 Hz tick / 1 Hz toggle at each oscillator rate.
  localparam int unsigned DEFAULT_DIV_50M = 32'd24_999_999;
  localparam int unsigned DEFAULT_DIV_25M = 32'd12_499_999;

  // Bits needed to address n channels, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        w = 32'(i + 1);
      end else begin
        w = w;
      end
    end
    if (w == 32'd0) begin
      return 32'd1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/osc_tick_chan.sv
// One tick channel: programmable down-counter with tick strobe and toggle output.
module osc_tick_chan
  import osc_tick_pkg::*;
#(
  parameter int unsigned          DIV_W       = 26,
  parameter logic [DIV_W-1:0]     DEFAULT_DIV = DIV_W'(DEFAULT_DIV_50M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_data,
  output logic             tick,
  output logic             toggle
);

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] div_d, div_q;
  logic [DIV_W-1:0] cnt_d, cnt_q;
  logic             tick_d, tick_q;
  logic             toggle_d, toggle_q;

  // Next-state: divisor write and the prioritised counter/output update.
  // Reloads always use div_q, so a divisor written on a reload edge
  // only governs the period after that reload.
  always_comb begin
    div_d    = div_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    toggle_d = toggle_q;

    if (wr) begin
      div_d = wr_data;
    end else begin
      div_d = div_q;
    end

    if (!en) begin
      cnt_d    = div_q;
      tick_d   = 1'b0;
      toggle_d = 1'b0;
    end else if (sync) begin
      cnt_d    = div_q;
      tick_d   = 1'b0;
      toggle_d = 1'b0;
    end else if (cnt_q == CNT_ZERO) begin
      cnt_d    = div_q;
      tick_d   = 1'b1;
      toggle_d = ~toggle_q;
    end else begin
      cnt_d    = cnt_q - CNT_ONE;
      tick_d   = 1'b0;
      toggle_d = toggle_q;
    end
  end

  // State and output registers; reset restores the default divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= DEFAULT_DIV;
      cnt_q    <= DEFAULT_DIV;
      tick_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      toggle_q <= toggle_d;
    end
  end

  assign tick   = tick_q;
  assign toggle = toggle_q;

endmodule

// File: rtl/osc_tick_gen.sv
// Multi-channel tick/blink generator: write-port decode plus NUM_CH channels.
module osc_tick_gen
  import osc_tick_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 26,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_50M
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic [NUM_CH-1:0]               EN,
  input  logic                            SYNC,
  input  logic                            WR_EN,
  input  logic [clog2_min1(NUM_CH)-1:0]   WR_CH,
  input  logic [DIV_W-1:0]                WR_DATA,
  output logic [NUM_CH-1:0]               TICK,
  output logic [NUM_CH-1:0]               TOGGLE
);

  logic [NUM_CH-1:0] wr_sel;

  // One-hot write select; out-of-range channel numbers match nothing.
  always_comb begin
    wr_sel = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (WR_EN && (int'(WR_CH) == i)) begin
        wr_sel[i] = 1'b1;
      end else begin
        wr_sel[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    osc_tick_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DIV_W'(DEFAULT_DIV))
    ) u_chan (
      .clk     (CLK),
      .rst_n   (RESET_N),
      .en      (EN[g]),
      .sync    (SYNC),
      .wr      (wr_sel[g]),
      .wr_data (WR_DATA),
      .tick    (TICK[g]),
      .toggle  (TOGGLE[g])
    );
  end

endmodule

// File: tb/tb_osc_tick_gen.sv
// Directed self-checking bench for osc_tick_gen (5 channels, small reset divisor).
module tb_osc_tick_gen;

  localparam int unsigned NCH  = 5;
  localparam int unsigned DW   = 26;
  localparam int unsigned DDEF = 5;

  logic            clk;
  logic            rst_n;
  logic [NCH-1:0]  en;
  logic            sync;
  logic            wr_en;
  logic [2:0]      wr_ch;
  logic [DW-1:0]   wr_data;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  tog;

  int n_cmp;
  int n_err;

  osc_tick_gen #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .DEFAULT_DIV (DDEF)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .EN      (en),
    .SYNC    (sync),
    .WR_EN   (wr_en),
    .WR_CH   (wr_ch),
    .WR_DATA (wr_data),
    .TICK    (tick),
    .TOGGLE  (tog)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] en;
    logic           wr_en;
    logic [2:0]     wr_ch;
    logic [DW-1:0]  wr_data;
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_tog;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] ch, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  vec_t vecs[15];
  int   divs[4];
  int   first_idx;
  logic [NCH-1:0] et;
  logic [NCH-1:0] eg;

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = 3'd0; wr_data = '0;

    // ch0 D=3: write while idle, one more idle edge to load cnt, then run
    vecs[0]  = '{5'b00000, 1'b1, 3'd0, 26'd3, 5'b00000, 5'b00000};
    vecs[1]  = '{5'b00000, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00000};
    vecs[2]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00000};
    vecs[3]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00000};
    vecs[4]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00000};
    vecs[5]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00001, 5'b00001};
    vecs[6]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00001};
    vecs[7]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00001};
    vecs[8]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00001};
    vecs[9]  = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00001, 5'b00000};
    vecs[10] = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00000};
    vecs[11] = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00000};
    vecs[12] = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00000};
    vecs[13] = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00001, 5'b00001};
    vecs[14] = '{5'b00001, 1'b0, 3'd0, 26'd0, 5'b00000, 5'b00001};

    // Reset state
    #23;
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_toggle", 32'(tog), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_reset_idle_tick", 32'(tick), 32'd0);

    // Table-driven: ch0 D=3
    for (int i = 0; i < 15; i++) begin
      en = vecs[i].en; wr_en = vecs[i].wr_en; wr_ch = vecs[i].wr_ch; wr_data = vecs[i].wr_data;
      step();
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].exp_tick));
      check($sformatf("vec%0d_toggle", i), 32'(tog), 32'(vecs[i].exp_tog));
    end
    wr_en = 1'b0;

    // D=0 on ch1: tick every cycle, toggle flips every cycle
    en = '0;
    do_write(3'd1, 26'd0);
    step();
    check("idle_tick", 32'(tick), 32'd0);
    en = 5'b00010;
    for (int j = 0; j < 6; j++) begin
      step();
      check($sformatf("d0_tick_%0d", j), 32'(tick), 32'(5'b00010));
      check($sformatf("d0_toggle_%0d", j), 32'(tog[1]), ((j % 2) == 0) ? 32'd1 : 32'd0);
    end

    // ch2 D=9, change to D=2 mid-count, out-of-range writes ignored
    en = '0;
    do_write(3'd2, 26'd9);
    step();
    en = 5'b00100;
    first_idx = -1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (tick[2] && first_idx < 0) begin
        first_idx = j;
        break;
      end
    end
    check("ch2_first_tick_latency", 32'(first_idx), 32'd9);
    for (int n = 1; n <= 17; n++) begin
      wr_en = 1'b0;
      if (n == 5) begin
        wr_en = 1'b1; wr_ch = 3'd2; wr_data = 26'd2;
      end else if (n == 11) begin
        wr_en = 1'b1; wr_ch = 3'd6; wr_data = 26'd0;
      end else if (n == 12) begin
        wr_en = 1'b1; wr_ch = 3'd7; wr_data = 26'd0;
      end
      step();
      et = (n == 10 || n == 13 || n == 16) ? 5'b00100 : 5'b00000;
      check($sformatf("ch2_midwrite_n%0d", n), 32'(tick), 32'(et));
    end
    wr_en = 1'b0;

    // ch0..3 D=4,6,9,12 all enabled, SYNC aligns them
    divs[0] = 4; divs[1] = 6; divs[2] = 9; divs[3] = 12;
    en = '0;
    for (int c = 0; c < 4; c++) do_write(3'(c), 26'(divs[c]));
    step();
    en = 5'b01111;
    for (int j = 0; j < 7; j++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_edge_tick", 32'(tick), 32'd0);
    check("sync_edge_toggle", 32'(tog), 32'd0);
    for (int n = 1; n <= 13; n++) begin
      step();
      et = '0; eg = '0;
      for (int c = 0; c < 4; c++) begin
        et[c] = ((n % (divs[c] + 1)) == 0);
        eg[c] = (((n / (divs[c] + 1)) % 2) == 1);
      end
      check($sformatf("sync_n%0d_tick", n), 32'(tick), 32'(et));
      check($sformatf("sync_n%0d_toggle", n), 32'(tog), 32'(eg));
    end

    // SYNC on a due tick suppresses it; write on a reload edge applies next period
    sync = 1'b1;
    step();
    sync = 1'b0;
    for (int m = 1; m <= 4; m++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_on_due_tick", 32'(tick), 32'd0);
    check("sync_on_due_toggle", 32'(tog), 32'd0);
    for (int m = 1; m <= 14; m++) begin
      wr_en = 1'b0;
      if (m == 5) begin
        wr_en = 1'b1; wr_ch = 3'd0; wr_data = 26'd1;
      end
      step();
      check($sformatf("reload_write_m%0d", m), 32'(tick[0]),
            (m == 5 || m == 10 || m == 12 || m == 14) ? 32'd1 : 32'd0);
    end
    wr_en = 1'b0;

    // Asynchronous reset mid-count, then default divisor period
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_tick", 32'(tick), 32'd0);
    check("async_reset_toggle", 32'(tog), 32'd0);
    en = 5'b00001;
    #7;
    rst_n = 1'b1;
    for (int m = 0; m <= 11; m++) begin
      step();
      check($sformatf("after_reset_m%0d", m), 32'(tick),
            (m == 5 || m == 11) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
